// File: rtl/uart_rx_frame.sv
// UART receive framer: after a confirmed start bit, samples data/parity/stop at bit centres
// on the oversample tick and hands each byte to a one-entry valid/ready holding register.
module uart_rx_frame #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bd8_rate,
   input  logic                 rx,
   input  logic                 start_ok,
   input  logic                 start_bit,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   input  logic                 clr_err,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic [TW-1:0]        r_tick_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_ferr;
   logic                 r_perr_held;
   logic                 r_overrun;
   logic                 w_sample;
   logic                 w_start;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_drop;
   logic                 w_par;

   // Line idles high, so the synchroniser resets to 1 to avoid a fake falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   assign w_sample = (r_state != S_IDLE) && bd8_rate && (r_tick_cnt == TW'(OVERSAMPLE - 1));
   assign w_par    = (^r_shift) ^ r_rx_s ^ (PARITY_ODD != 0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_push  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_ok && !start_bit) begin
               w_next  = S_DATA;
               w_start = 1'b1;
            end
         end
         S_DATA: begin
            if (w_sample && (r_bit_cnt == BW'(DATA_BITS - 1)))
               w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (w_sample) w_next = S_STOP;
         end
         S_STOP: begin
            if (w_sample) begin
               w_next = S_IDLE;
               w_push = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Data arrives LSB first, so shifting in from the top leaves bit 0 in position 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
      end else if (w_start) begin
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
      end else if ((r_state != S_IDLE) && bd8_rate) begin
         r_tick_cnt <= w_sample ? '0 : r_tick_cnt + TW'(1);
         if (w_sample && (r_state == S_DATA)) begin
            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
         end
         if (w_sample && (r_state == S_PARITY)) r_perr <= w_par;
      end
   end

   // Holding register: a transfer happens on any cycle with rx_valid & rx_ready; a new byte
   // may load in that same cycle, otherwise a byte arriving while full is dropped.
   assign w_pop  = r_valid && rx_ready;
   assign w_drop = w_push && r_valid && !w_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_ferr      <= 1'b0;
         r_perr_held <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_push && !w_drop) begin
            r_data      <= r_shift;
            r_ferr      <= ~r_rx_s;
            r_perr_held <= (PARITY_EN != 0) ? r_perr : 1'b0;
            r_valid     <= 1'b1;
         end else if (w_pop) begin
            r_valid <= 1'b0;
         end
         if (w_drop)       r_overrun <= 1'b1;
         else if (clr_err) r_overrun <= 1'b0;
      end
   end

   assign rx_data    = r_data;
   assign rx_valid   = r_valid;
   assign frame_err  = r_ferr;
   assign parity_err = r_perr_held;
   assign overrun    = r_overrun;
   assign busy       = (r_state != S_IDLE);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frames with literal expectations, then random frames,
// all compared every cycle against a byte-level model of the holding register.
module tb_uart_rx_frame;

   localparam int DB   = 8;
   localparam int OS   = 8;
   localparam int PEN  = 1;
   localparam int PODD = 0;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          bd8_rate  = 1'b0;
   logic          rx        = 1'b1;
   logic          start_ok  = 1'b0;
   logic          start_bit = 1'b1;
   logic          rx_ready  = 1'b0;
   logic          clr_err   = 1'b0;
   logic [DB-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          parity_err;
   logic          overrun;
   logic          busy;
   logic [1:0]    dbg_state;

   uart_rx_frame #(
      .DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(PEN), .PARITY_ODD(PODD)
   ) dut (
      .clk(clk), .rst(rst), .bd8_rate(bd8_rate), .rx(rx), .start_ok(start_ok),
      .start_bit(start_bit), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .clr_err(clr_err),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;
   bit rand_ctl = 1'b0;
   bit mid_start_en = 1'b0;
   bit ready_on_push = 1'b0;

   // Events announced by the driver: a frame begins, or the stop bit is sampled.
   logic          ev_start = 1'b0;
   logic          ev_push  = 1'b0;
   logic [DB-1:0] ev_data  = '0;
   logic          ev_ferr  = 1'b0;
   logic          ev_perr  = 1'b0;

   logic          m_valid = 1'b0;
   logic [DB-1:0] m_data  = '0;
   logic          m_ferr  = 1'b0;
   logic          m_perr  = 1'b0;
   logic          m_ovr   = 1'b0;
   logic          m_busy  = 1'b0;
   logic          m_pop;
   logic          m_drop;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic exp_perr(input logic [DB-1:0] d, input logic p);
      return (PEN != 0) ? ((^d) ^ p ^ (PODD != 0)) : 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      end else begin
         m_pop  = m_valid && rx_ready;
         m_drop = ev_push && m_valid && !m_pop;
         if (ev_push && !m_drop) begin
            m_valid = 1'b1; m_data = ev_data; m_ferr = ev_ferr; m_perr = ev_perr;
         end else if (m_pop) begin
            m_valid = 1'b0;
         end
         if (m_drop)       m_ovr = 1'b1;
         else if (clr_err) m_ovr = 1'b0;
         if (ev_start) m_busy = 1'b1;
         if (ev_push)  m_busy = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if ({rx_valid, rx_data, frame_err, parity_err, overrun, busy} !==
             {m_valid, m_data, m_ferr, m_perr, m_ovr, m_busy}) begin
            n_errors++;
            if (n_errors < 20)
               $display("FAIL cycle t=%0t got v=%b d=%h f=%b p=%b o=%b b=%b expected v=%b d=%h f=%b p=%b o=%b b=%b",
                        $time, rx_valid, rx_data, frame_err, parity_err, overrun, busy,
                        m_valid, m_data, m_ferr, m_perr, m_ovr, m_busy);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ctl) begin
            rx_ready = ($urandom_range(0, 3) != 0);
            clr_err  = ($urandom_range(0, 15) == 0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input logic b, input bit last);
      int gap;
      rx = b;
      for (int t = 0; t < OS; t++) begin
         gap = ($urandom_range(0, 40) == 0) ? 20 : $urandom_range(0, 2);
         repeat (gap) cyc();
         bd8_rate = 1'b1;
         if (mid_start_en && t == 3 && $urandom_range(0, 7) == 0) begin
            start_ok = 1'b1; start_bit = 1'b0;
         end
         if (last && t == OS - 1) begin
            ev_push = 1'b1;
            if (ready_on_push) rx_ready = 1'b1;
         end
         cyc();
         bd8_rate = 1'b0; start_ok = 1'b0; start_bit = 1'b1;
         if (ev_push) begin
            ev_push = 1'b0;
            if (ready_on_push) rx_ready = 1'b0;
         end
      end
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stop,
                             input int abort_bit);
      rx = 1'b0;
      cyc();
      start_ok = 1'b1; start_bit = 1'b0; ev_start = 1'b1;
      cyc();
      start_ok = 1'b0; start_bit = 1'b1; ev_start = 1'b0;
      ev_data = d; ev_ferr = ~stop; ev_perr = exp_perr(d, pbit);
      for (int i = 0; i < DB; i++) begin
         if (i == abort_bit) begin
            rst = 1'b1;
            repeat (3) cyc();
            rst = 1'b0;
            rx = 1'b1;
            return;
         end
         send_bit(d[i], 1'b0);
      end
      if (PEN != 0) send_bit(pbit, 1'b0);
      send_bit(stop, 1'b1);
      rx = 1'b1;
   endtask

   task automatic pop();
      rx_ready = 1'b1;
      cyc();
      rx_ready = 1'b0;
   endtask

   initial begin
      logic [DB-1:0] d;
      #1 rst = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_valid", rx_valid, 0);
      check("reset_data", rx_data, 0);
      check("reset_busy", busy, 0);
      check("reset_overrun", overrun, 0);
      cyc();
      rst = 1'b0;
      repeat (2) cyc();

      send_frame(8'hA5, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("a5_valid", rx_valid, 1);
      check("a5_data", rx_data, 8'hA5);
      check("a5_ferr", frame_err, 0);
      pop();
      @(negedge clk);
      check("a5_popped", rx_valid, 0);

      send_frame(8'h3C, 1'b0, 1'b0, -1);
      @(negedge clk);
      check("3c_data", rx_data, 8'h3C);
      check("3c_ferr", frame_err, 1);
      pop();
      send_frame(8'h5A, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("5a_ferr", frame_err, 0);
      pop();

      send_frame(8'h07, 1'b1, 1'b1, -1);
      @(negedge clk);
      check("07_par_ok", parity_err, 0);
      pop();
      send_frame(8'h07, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("07_par_bad", parity_err, 1);
      pop();

      send_frame(8'h11, 1'b0, 1'b1, -1);
      send_frame(8'h22, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("ovr_data", rx_data, 8'h11);
      check("ovr_flag", overrun, 1);
      pop();
      @(negedge clk);
      check("ovr_popped", rx_valid, 0);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      @(negedge clk);
      check("ovr_cleared", overrun, 0);

      send_frame(8'h33, 1'b0, 1'b1, -1);
      ready_on_push = 1'b1;
      send_frame(8'h44, 1'b0, 1'b1, -1);
      ready_on_push = 1'b0;
      @(negedge clk);
      check("same_cycle_data", rx_data, 8'h44);
      check("same_cycle_ovr", overrun, 0);
      check("same_cycle_valid", rx_valid, 1);
      pop();

      start_ok = 1'b1; start_bit = 1'b1;
      cyc();
      start_ok = 1'b0;
      repeat (20) begin
         bd8_rate = 1'b1; cyc(); bd8_rate = 1'b0; cyc();
      end
      @(negedge clk);
      check("false_start_busy", busy, 0);
      check("false_start_valid", rx_valid, 0);

      send_frame(8'h96, 1'b0, 1'b1, 3);
      @(negedge clk);
      check("midreset_data", rx_data, 0);
      check("midreset_busy", busy, 0);
      send_frame(8'h81, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("after_reset_data", rx_data, 8'h81);
      check("after_reset_valid", rx_valid, 1);
      pop();

      rand_ctl = 1'b1;
      mid_start_en = 1'b1;
      for (int n = 0; n < 40; n++) begin
         d = DB'($urandom);
         send_frame(d, 1'($urandom), ($urandom_range(0, 5) != 0), -1);
         if ($urandom_range(0, 3) == 0) begin
            start_ok = 1'b1; start_bit = 1'b1;
            cyc();
            start_ok = 1'b0;
         end
         repeat ($urandom_range(0, 4)) cyc();
      end
      rand_ctl = 1'b0;
      mid_start_en = 1'b0;
      cyc();
      clr_err = 1'b0;
      rx_ready = 1'b1;
      repeat (5) cyc();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
